// File: rtl/spi_boot_master.sv
// SPI mode-0 master that turns 32-bit word write/read requests into the
// PULPino SPI slave's memory-access frames (command, address, dummy, data).
//   state  | meaning
//   S_IDLE | CS high, accepting a request
//   S_LOW  | SCK low, MOSI holds current bit
//   S_HIGH | SCK high, MISO sampled on entry
//   S_HOLD | SCK low after last bit, CS still asserted
//   S_GAP  | CS high before returning to idle
module spi_boot_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter logic [7:0]  CMD_WRITE    = 8'h02,
  parameter logic [7:0]  CMD_READ     = 8'h0B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_clk_o,
  output logic        spi_csn_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
);

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

  localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [8:0] N_WRITE_M1 = 9'd71;
  localparam logic [8:0] N_READ_M1  = 9'(71 + DUMMY_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic        div_tc;
  logic [8:0]  bits_left;
  logic [71:0] tx;
  logic [31:0] rx;
  logic        is_write;
  logic        rst_done;
  logic        accept;

  assign div_tc    = (div_cnt == 8'd0);
  assign req_ready = rst_done && (state == S_IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    spi_csn_o = 1'b1;
    spi_clk_o = 1'b0;
    spi_sdo_o = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOW;
      S_LOW: begin
        spi_csn_o = 1'b0;
        spi_sdo_o = tx[71];
        if (div_tc) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        spi_csn_o = 1'b0;
        spi_clk_o = 1'b1;
        spi_sdo_o = tx[71];
        if (div_tc) state_nxt = (bits_left == 9'd0) ? S_HOLD : S_LOW;
      end
      S_HOLD: begin
        spi_csn_o = 1'b0;
        if (div_tc) state_nxt = S_GAP;
      end
      S_GAP: if (div_tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_done  <= 1'b0;
      div_cnt   <= 8'd0;
      bits_left <= 9'd0;
      tx        <= '0;
      rx        <= '0;
      is_write  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rst_done  <= 1'b1;
      rsp_valid <= 1'b0;
      if (state != state_nxt)  div_cnt <= DIV_LOAD;
      else if (!div_tc)        div_cnt <= div_cnt - 8'd1;
      if (accept) begin
        is_write  <= req_write;
        bits_left <= req_write ? N_WRITE_M1 : N_READ_M1;
        tx        <= req_write ? {CMD_WRITE, req_addr, req_wdata}
                               : {CMD_READ, req_addr, 32'h0};
      end
      // Only the final 32 bit slots of a read carry slave data.
      if (state == S_LOW && div_tc && !is_write && bits_left < 9'd32)
        rx <= {rx[30:0], spi_sdi_i};
      if (state == S_HIGH && div_tc && bits_left != 9'd0) begin
        tx        <= {tx[70:0], 1'b0};
        bits_left <= bits_left - 9'd1;
      end
      if (state == S_HOLD && div_tc) begin
        rsp_valid <= 1'b1;
        if (!is_write) rsp_rdata <= rx;
      end
    end
  end

endmodule

// File: tb/tb_spi_boot_master.sv
// Directed bench for spi_boot_master: one instance at default timing and one
// at CLK_DIV=1/DUMMY_CYCLES=0, each paired with a behavioural SPI slave.
module tb_spi_boot_master;

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_valid [2] = '{1'b0, 1'b0};
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        busy [2];
  logic        sclk [2];
  logic        csn [2];
  logic        sdo [2];
  logic        sdi [2];

  logic [31:0]  sdata [2] = '{32'h0, 32'h0};
  int           rise_cnt [2] = '{0, 0};
  int           rsp_cnt [2] = '{0, 0};
  logic [127:0] mosi_sh [2] = '{128'h0, 128'h0};
  logic         csn_q [2] = '{1'b1, 1'b1};
  logic         sclk_q [2] = '{1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_boot_master u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .spi_clk_o(sclk[0]), .spi_csn_o(csn[0]), .spi_sdo_o(sdo[0]), .spi_sdi_i(sdi[0])
  );

  spi_boot_master #(.CLK_DIV(1), .DUMMY_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .spi_clk_o(sclk[1]), .spi_csn_o(csn[1]), .spi_sdo_o(sdo[1]), .spi_sdi_i(sdi[1])
  );

  function automatic int cdiv(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int dum(input int d);
    return (d == 0) ? 32 : 0;
  endfunction

  // Slave: MISO carries sdata MSB first in the last 32 bit slots of the frame.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      sdi[g] = 1'b0;
      if (rise_cnt[g] >= 40 + dum(g) && rise_cnt[g] < 72 + dum(g))
        sdi[g] = sdata[g][31 - (rise_cnt[g] - 40 - dum(g))];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (csn_q[g] && !csn[g]) begin
        rise_cnt[g] <= 0;
        mosi_sh[g]  <= '0;
      end else if (!csn[g] && sclk[g] && !sclk_q[g]) begin
        rise_cnt[g] <= rise_cnt[g] + 1;
        mosi_sh[g]  <= {mosi_sh[g][126:0], sdo[g]};
      end
      if (rsp_valid[g]) rsp_cnt[g] <= rsp_cnt[g] + 1;
      csn_q[g]  <= csn[g];
      sclk_q[g] <= sclk[g];
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit keep);
    @(negedge clk);
    req_write    = wr;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) req_valid[d] = 1'b0;
    chk("accept_cs_low", csn[d], 0);
  endtask

  task automatic wait_rsp(input int d, input int exp_lat);
    int k = 0;
    while (!rsp_valid[d] && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rsp_latency", k + 1, exp_lat);
    chk("cs_high_at_rsp", csn[d], 1);
  endtask

  task automatic check_frame(input int d, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata);
    logic [127:0] e;
    e = {56'h0, wr ? 8'h02 : 8'h0B, addr, wr ? wdata : 32'h0};
    if (!wr) e = e << dum(d);
    chk("sck_rises", rise_cnt[d], wr ? 72 : 72 + dum(d));
    chk("mosi_frame", mosi_sh[d], e);
    chk("rsp_rdata", rsp_rdata[d], rdata);
  endtask

  task automatic wait_ready(input int d);
    int j = 0;
    bit cs_ok = 1'b1;
    logic pulse_after = 1'b0;
    while (!req_ready[d] && j < 1000) begin
      if (csn[d] !== 1'b1) cs_ok = 1'b0;
      @(posedge clk);
      #1;
      j++;
      if (j == 1) pulse_after = rsp_valid[d];
    end
    chk("ready_after_rsp", j, cdiv(d));
    chk("cs_high_in_gap", cs_ok, 1);
    chk("rsp_one_cycle", pulse_after, 0);
  endtask

  vec_t vecs [5];

  initial begin
    int c0;
    vecs[0] = '{0, 1'b1, 32'h1A000000, 32'hDEADBEEF, 32'h0,        581, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h00080010, 32'h0,        32'h12345678, 837, 32'h12345678};
    vecs[2] = '{0, 1'b1, 32'h00000004, 32'hCAFEF00D, 32'h0,        581, 32'h12345678};
    vecs[3] = '{1, 1'b0, 32'h00000000, 32'h0,        32'hA5A5A5A5, 146, 32'hA5A5A5A5};
    vecs[4] = '{1, 1'b1, 32'h00000100, 32'h0F0F1234, 32'h0,        146, 32'hA5A5A5A5};

    repeat (4) @(posedge clk);
    #1;
    chk("rst_csn", csn[0], 1);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_sdo", sdo[0], 0);
    chk("rst_ready", req_ready[0], 0);
    chk("rst_busy", busy[0], 1);
    chk("rst_rsp_valid", rsp_valid[0], 0);
    chk("rst_rdata", rsp_rdata[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", req_ready[0], 1);
    chk("idle_busy", busy[0], 0);

    for (int i = 0; i < 5; i++) begin
      sdata[vecs[i].d] = vecs[i].sdata;
      launch(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
      wait_rsp(vecs[i].d, vecs[i].lat);
      check_frame(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
      wait_ready(vecs[i].d);
    end

    // Back-to-back writes with req_valid held; fields change mid-frame.
    launch(0, 1'b1, 32'h00000010, 32'h11111111, 1'b1);
    @(negedge clk);
    req_addr  = 32'h00000020;
    req_wdata = 32'h22222222;
    wait_rsp(0, 581);
    check_frame(0, 1'b1, 32'h00000010, 32'h11111111, 32'h12345678);
    wait_ready(0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("b2b_second_accept", csn[0], 0);
    wait_rsp(0, 581);
    check_frame(0, 1'b1, 32'h00000020, 32'h22222222, 32'h12345678);
    wait_ready(0);

    // Reset in the address phase of a read.
    launch(0, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    chk("addr_phase_sdo", sdo[0], 1);
    @(negedge clk);
    rst_n = 1'b0;
    c0 = rsp_cnt[0];
    @(posedge clk);
    #1;
    chk("midrst_csn", csn[0], 1);
    chk("midrst_sclk", sclk[0], 0);
    chk("midrst_sdo", sdo[0], 0);
    chk("midrst_ready", req_ready[0], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_ready", req_ready[0], 1);
    repeat (900) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_cnt[0], c0);
    launch(0, 1'b1, 32'h1A000040, 32'h0BADF00D, 1'b0);
    wait_rsp(0, 581);
    check_frame(0, 1'b1, 32'h1A000040, 32'h0BADF00D, 32'h0);
    wait_ready(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
